// File: rtl/trans_pkg.sv
// Shared transformer-datapath constants and helpers.
// Used by the mean/variance accumulators and divide768.
package trans_pkg;

    localparam int HIDDEN_DIM = 768;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1)
            r++;
        return r;
    endfunction

    function automatic int beats(input int lanes);
        return HIDDEN_DIM / lanes;
    endfunction

endpackage

// File: rtl/accum768_if.sv
// Beat input / token-sum output bundle of accum768.
// The producer owns the master side; accum768 is the slave.
interface accum768_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int SUM_WIDTH  = 18
);
    logic [LANES*DATA_WIDTH-1:0] datain;
    logic                        datain_valid_n;
    logic                        sync_clr;
    logic signed [SUM_WIDTH-1:0] sum;
    logic                        sum_valid_n;
    logic                        busy;

    modport master (
        output datain, datain_valid_n, sync_clr,
        input  sum, sum_valid_n, busy
    );

    modport slave (
        input  datain, datain_valid_n, sync_clr,
        output sum, sum_valid_n, busy
    );
endinterface

// File: rtl/lane_adder_tree.sv
// Combinational reduction of N pre-extended signed lanes.
// Registering is left to the caller.
module lane_adder_tree #(
    parameter int W = 18,
    parameter int N = 4
) (
    input  logic [N*W-1:0]  vals,
    output logic signed [W-1:0] total
);
    always_comb begin
        total = '0;
        for (int i = 0; i < N; i++)
            total = total + $signed(vals[i*W +: W]);
    end
endmodule

// File: rtl/short2long.sv
// Signed width extension of one element.
// Used wherever a narrow operand joins a wider datapath.
module short2long #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 18
) (
    input  logic signed [IN_W-1:0]  short_val,
    output logic signed [OUT_W-1:0] long_val
);
    assign long_val = OUT_W'(short_val);
endmodule

// File: rtl/accum768.sv
// Two-stage token accumulator: lane sum, then running sum over BEATS beats.
// Emits the signed token sum with a one-cycle active-low strobe.
module accum768
    import trans_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int SUM_WIDTH  = 18
) (
    input  logic       clk_p,
    input  logic       rst_n,
    accum768_if.slave  bus
);
    localparam int BEATS = beats(LANES);
    localparam int CNT_W = clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [LANES*SUM_WIDTH-1:0]  ext;
    logic signed [SUM_WIDTH-1:0] tree_sum;
    logic signed [SUM_WIDTH-1:0] lane_sum_r;
    logic signed [SUM_WIDTH-1:0] acc, acc_nxt;
    logic signed [SUM_WIDTH-1:0] sum_r, sum_nxt, add;
    logic [CNT_W-1:0]            beat_cnt, cnt_nxt;
    logic lane_vld_r, vld_nxt;
    logic svn_r, svn_nxt;
    logic busy_r, busy_nxt;
    logic clr, fin, step;

    for (genvar i = 0; i < LANES; i++) begin : g_ext
        short2long #(
            .IN_W  (DATA_WIDTH),
            .OUT_W (SUM_WIDTH)
        ) u_ext (
            .short_val (bus.datain[i*DATA_WIDTH +: DATA_WIDTH]),
            .long_val  (ext[i*SUM_WIDTH +: SUM_WIDTH])
        );
    end

    lane_adder_tree #(
        .W (SUM_WIDTH),
        .N (LANES)
    ) u_tree (
        .vals  (ext),
        .total (tree_sum)
    );

    // Clear outranks both a completing and an ordinary beat.
    assign clr  = bus.sync_clr;
    assign fin  = ~clr & lane_vld_r & (beat_cnt == LAST);
    assign step = ~clr & lane_vld_r & (beat_cnt != LAST);
    assign add  = acc + lane_sum_r;

    always_comb begin
        acc_nxt = acc;
        cnt_nxt = beat_cnt;
        sum_nxt = sum_r;
        svn_nxt = 1'b1;
        vld_nxt = ~bus.datain_valid_n & ~clr;
        unique case (1'b1)
            clr: begin
                acc_nxt = '0;
                cnt_nxt = '0;
            end
            fin: begin
                sum_nxt = add;
                svn_nxt = 1'b0;
                acc_nxt = '0;
                cnt_nxt = '0;
            end
            step: begin
                acc_nxt = add;
                cnt_nxt = beat_cnt + 1'b1;
            end
            default: ;
        endcase
        busy_nxt = (cnt_nxt != '0) | vld_nxt;
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            lane_sum_r <= '0;
            lane_vld_r <= 1'b0;
            acc        <= '0;
            beat_cnt   <= '0;
            sum_r      <= '0;
            svn_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            if (!bus.datain_valid_n)
                lane_sum_r <= tree_sum;
            lane_vld_r <= vld_nxt;
            acc        <= acc_nxt;
            beat_cnt   <= cnt_nxt;
            sum_r      <= sum_nxt;
            svn_r      <= svn_nxt;
            busy_r     <= busy_nxt;
        end
    end

    assign bus.sum         = sum_r;
    assign bus.sum_valid_n = svn_r;
    assign bus.busy        = busy_r;
endmodule
